// File: rtl/pipwb_rv32_pkg.sv
// Shared decoded-op header for the RV32I pipeline: op codes, OpType bit positions, WB state encoding.
// Latency: n/a (types and constants only). Backpressure: n/a.
// Ports: none. Also provides the load misalignment rule used at write-back accept.
package pipwb_rv32_pkg;

  // Bit positions inside the one-hot iOpType group
  localparam int OPT_LOAD   = 5;
  localparam int OPT_STORE  = 4;
  localparam int OPT_ALUI   = 3;
  localparam int OPT_ALUR   = 2;
  localparam int OPT_BRANCH = 1;
  localparam int OPT_UPJ    = 0;

  // Decoded operation codes (10-bit field of the decoded-op header)
  localparam logic [9:0] OP_LB     = 10'h000;
  localparam logic [9:0] OP_LH     = 10'h001;
  localparam logic [9:0] OP_LW     = 10'h002;
  localparam logic [9:0] OP_LBU    = 10'h004;
  localparam logic [9:0] OP_LHU    = 10'h005;
  localparam logic [9:0] OP_SW     = 10'h102;
  localparam logic [9:0] OP_ADD    = 10'h010;
  localparam logic [9:0] OP_ADDI   = 10'h020;
  localparam logic [9:0] OP_BEQ    = 10'h040;
  localparam logic [9:0] OP_LUI    = 10'h080;
  localparam logic [9:0] OP_JAL    = 10'h081;
  localparam logic [9:0] OP_NOTSUP = 10'h3FF;

  typedef enum logic [0:0] {
    WB_IDLE      = 1'b0,
    WB_WAIT_LOAD = 1'b1
  } wb_state_e;

  // Word loads need addr[1:0]==0, half loads need addr[0]==0; byte loads never trap.
  function automatic logic load_misaligned(logic [9:0] op, logic [1:0] addr);
    return ((op == OP_LW) && (addr != 2'b00)) ||
           (((op == OP_LH) || (op == OP_LHU)) && addr[0]);
  endfunction

endpackage

// File: rtl/pipwb_rv32_load_align.sv
// Load byte/half lane select plus sign/zero extension of a little-endian data-memory word.
// Latency: combinational. Backpressure: none.
// Ports: op_i (decoded load op), addr_i (address low bits), word_i (memory word), data_o (extended result).
module load_align_rv32
  import pipwb_rv32_pkg::*;
(
  input  logic [9:0]  op_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (addr_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

    data_o = word_i;
    case (op_i)
      OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data_o = {24'd0, byte_sel};
      OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data_o = {16'd0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/pipwb_rv32.sv
// RV32I write-back stage: retires execute ops, waits on load data, drives one register-bank write per op.
// Latency: 1 cycle for non-loads (full throughput); loads write 1 cycle after the memory response.
// Backpressure: oEXReady drops while a load waits for its response; optional timeout via WB_LOAD_TIMEOUT_EN.
// Ports: iCLK/iRST (sync, active-high); iEXValid/oEXReady handshake with iOpType, iDecodedOP, iDregADDR,
// iALUDATA; iDMemValid/iDMemDATA load response; oDregADDR/oDregDATA/oDregWE bank write; oLoadMisalign,
// oIllegal (and oBusErr when WB_LOAD_TIMEOUT_EN is defined) pulses; oRetireCnt retired-op counter.
module pipwb_rv32
  import pipwb_rv32_pkg::*;
#(
  parameter int RETIRE_W = 32
`ifdef WB_LOAD_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iEXValid,
  output logic                oEXReady,
  input  logic [5:0]          iOpType,
  input  logic [9:0]          iDecodedOP,
  input  logic [4:0]          iDregADDR,
  input  logic [31:0]         iALUDATA,
  input  logic                iDMemValid,
  input  logic [31:0]         iDMemDATA,
  output logic [4:0]          oDregADDR,
  output logic [31:0]         oDregDATA,
  output logic                oDregWE,
`ifdef WB_LOAD_TIMEOUT_EN
  output logic                oBusErr,
`endif
  output logic                oLoadMisalign,
  output logic                oIllegal,
  output logic [RETIRE_W-1:0] oRetireCnt
);

  wb_state_e           state_q;
  logic [9:0]          ld_op_q;
  logic [4:0]          ld_rd_q;
  logic [1:0]          ld_addr_q;
  logic [4:0]          dreg_addr_q;
  logic [31:0]         dreg_data_q;
  logic                dreg_we_q;
  logic                misalign_q;
  logic                illegal_q;
  logic [RETIRE_W-1:0] retire_cnt_q;
  logic [31:0]         ld_data_d;
  logic                rf_write_d;
`ifdef WB_LOAD_TIMEOUT_EN
  logic                bus_err_q;
  logic [15:0]         tmo_cnt_q;
`endif

  load_align_rv32 u_align (
    .op_i   (ld_op_q),
    .addr_i (ld_addr_q),
    .word_i (iDMemDATA),
    .data_o (ld_data_d)
  );

  // Only ALU/upper/jump groups write; a malformed one-hot that also flags store/branch is treated as no-write.
  assign rf_write_d = (iOpType[OPT_ALUI] | iOpType[OPT_ALUR] | iOpType[OPT_UPJ]) &
                      ~(iOpType[OPT_STORE] | iOpType[OPT_BRANCH]);

  assign oEXReady      = (state_q == WB_IDLE);
  assign oDregADDR     = dreg_addr_q;
  assign oDregDATA     = dreg_data_q;
  assign oDregWE       = dreg_we_q;
  assign oLoadMisalign = misalign_q;
  assign oIllegal      = illegal_q;
  assign oRetireCnt    = retire_cnt_q;
`ifdef WB_LOAD_TIMEOUT_EN
  assign oBusErr       = bus_err_q;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q      <= WB_IDLE;
      ld_op_q      <= '0;
      ld_rd_q      <= '0;
      ld_addr_q    <= '0;
      dreg_addr_q  <= '0;
      dreg_data_q  <= '0;
      dreg_we_q    <= 1'b0;
      misalign_q   <= 1'b0;
      illegal_q    <= 1'b0;
      retire_cnt_q <= '0;
`ifdef WB_LOAD_TIMEOUT_EN
      bus_err_q    <= 1'b0;
      tmo_cnt_q    <= '0;
`endif
    end else begin
      // Outputs are one-cycle strobes; address/data stay zero whenever no write is driven.
      dreg_addr_q <= '0;
      dreg_data_q <= '0;
      dreg_we_q   <= 1'b0;
      misalign_q  <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
      bus_err_q   <= 1'b0;
`endif
      case (state_q)
        WB_IDLE: begin
          if (iEXValid) begin
            if (iDecodedOP == OP_NOTSUP) begin
              illegal_q    <= 1'b1;
              retire_cnt_q <= retire_cnt_q + RETIRE_W'(1);
            end else if (iOpType[OPT_LOAD]) begin
              if (load_misaligned(iDecodedOP, iALUDATA[1:0])) begin
                misalign_q   <= 1'b1;
                retire_cnt_q <= retire_cnt_q + RETIRE_W'(1);
              end else begin
                ld_op_q   <= iDecodedOP;
                ld_rd_q   <= iDregADDR;
                ld_addr_q <= iALUDATA[1:0];
                state_q   <= WB_WAIT_LOAD;
`ifdef WB_LOAD_TIMEOUT_EN
                tmo_cnt_q <= '0;
`endif
              end
            end else begin
              retire_cnt_q <= retire_cnt_q + RETIRE_W'(1);
              if (rf_write_d && (iDregADDR != 5'd0)) begin
                dreg_we_q   <= 1'b1;
                dreg_addr_q <= iDregADDR;
                dreg_data_q <= iALUDATA;
              end
            end
          end
        end
        WB_WAIT_LOAD: begin
          if (iDMemValid) begin
            retire_cnt_q <= retire_cnt_q + RETIRE_W'(1);
            state_q      <= WB_IDLE;
            if (ld_rd_q != 5'd0) begin
              dreg_we_q   <= 1'b1;
              dreg_addr_q <= ld_rd_q;
              dreg_data_q <= ld_data_d;
            end
          end
`ifdef WB_LOAD_TIMEOUT_EN
          else if (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            // Abandon: retire as a bus error; any later response lands in IDLE and is dropped.
            bus_err_q    <= 1'b1;
            retire_cnt_q <= retire_cnt_q + RETIRE_W'(1);
            state_q      <= WB_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
`endif
        end
        default: state_q <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipwb_rv32.sv
module tb_pipwb_rv32;
  import pipwb_rv32_pkg::*;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iEXValid = 1'b0;
  logic        oEXReady;
  logic [5:0]  iOpType = '0;
  logic [9:0]  iDecodedOP = '0;
  logic [4:0]  iDregADDR = '0;
  logic [31:0] iALUDATA = '0;
  logic        iDMemValid = 1'b0;
  logic [31:0] iDMemDATA = '0;
  logic [4:0]  oDregADDR;
  logic [31:0] oDregDATA;
  logic        oDregWE;
  logic        oLoadMisalign;
  logic        oIllegal;
  logic [31:0] oRetireCnt;
`ifdef WB_LOAD_TIMEOUT_EN
  logic        oBusErr;
`endif

  pipwb_rv32 #(
    .RETIRE_W(32)
`ifdef WB_LOAD_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iEXValid(iEXValid), .oEXReady(oEXReady),
    .iOpType(iOpType), .iDecodedOP(iDecodedOP), .iDregADDR(iDregADDR), .iALUDATA(iALUDATA),
    .iDMemValid(iDMemValid), .iDMemDATA(iDMemDATA),
    .oDregADDR(oDregADDR), .oDregDATA(oDregDATA), .oDregWE(oDregWE),
`ifdef WB_LOAD_TIMEOUT_EN
    .oBusErr(oBusErr),
`endif
    .oLoadMisalign(oLoadMisalign), .oIllegal(oIllegal), .oRetireCnt(oRetireCnt)
  );

  always #5 iCLK = ~iCLK;

  int          vecs = 0;
  int          miss = 0;
  logic [31:0] exp_cnt = 0;

  typedef struct {
    logic [5:0]  ot;
    logic [9:0]  op;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        we;
    logic [31:0] data;
    logic        ill;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    vecs++;
    if (act !== expv) begin
      miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
    end
  endtask

  // Full output check after a retire (or idle) cycle; address/data must be zero when no write.
  task automatic chk_out(input string nm, input logic we, input logic [4:0] rd, input logic [31:0] data,
                         input logic mis, input logic ill);
    chk({nm, ".we"}, 32'(oDregWE), 32'(we));
    chk({nm, ".addr"}, 32'(oDregADDR), we ? 32'(rd) : 32'd0);
    chk({nm, ".data"}, oDregDATA, we ? data : 32'd0);
    chk({nm, ".misalign"}, 32'(oLoadMisalign), 32'(mis));
    chk({nm, ".illegal"}, 32'(oIllegal), 32'(ill));
    chk({nm, ".retire"}, oRetireCnt, exp_cnt);
  endtask

  // Drive one op at a negedge; returns at the next negedge with the accept edge's outputs visible.
  task automatic send(input logic [5:0] ot, input logic [9:0] op, input logic [4:0] rd, input logic [31:0] alu);
    iEXValid = 1'b1; iOpType = ot; iDecodedOP = op; iDregADDR = rd; iALUDATA = alu;
    @(negedge iCLK);
    iEXValid = 1'b0;
  endtask

  function automatic logic [31:0] ld_ref(input logic [9:0] op, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] s;
    s = w >> (8 * a);
    case (op)
      OP_LB:   return {{24{s[7]}}, s[7:0]};
      OP_LBU:  return {24'd0, s[7:0]};
      OP_LH:   return {{16{s[15]}}, s[15:0]};
      OP_LHU:  return {16'd0, s[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic misal_ref(input logic [9:0] op, input logic [31:0] a);
    if (op == OP_LW) return (a % 4) != 0;
    if (op == OP_LH || op == OP_LHU) return (a % 2) != 0;
    return 1'b0;
  endfunction

  // Aligned load with response dly cycles after the first wait cycle.
  task automatic load_seq(input string nm, input logic [9:0] op, input logic [4:0] rd, input logic [31:0] ea,
                          input int dly, input logic [31:0] word, input logic [31:0] expv);
    send(6'b100000, op, rd, ea);
    chk({nm, ".rdy_wait"}, 32'(oEXReady), 32'd0);
    chk({nm, ".we_wait"}, 32'(oDregWE), 32'd0);
    for (int i = 0; i < dly; i++) begin
      @(negedge iCLK);
      chk({nm, ".rdy_wait"}, 32'(oEXReady), 32'd0);
    end
    iDMemValid = 1'b1; iDMemDATA = word;
    @(negedge iCLK);
    iDMemValid = 1'b0;
    exp_cnt++;
    chk_out(nm, rd != 5'd0, rd, expv, 1'b0, 1'b0);
    chk({nm, ".rdy_done"}, 32'(oEXReady), 32'd1);
  endtask

  task automatic misal_seq(input string nm, input logic [9:0] op, input logic [4:0] rd, input logic [31:0] ea);
    send(6'b100000, op, rd, ea);
    exp_cnt++;
    chk_out(nm, 1'b0, rd, 32'd0, 1'b1, 1'b0);
    chk({nm, ".rdy"}, 32'(oEXReady), 32'd1);
    // A response for the dropped access must be ignored.
    iDMemValid = 1'b1; iDMemDATA = 32'hDEADBEEF;
    @(negedge iCLK);
    iDMemValid = 1'b0;
    chk_out({nm, ".late"}, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
  endtask

  vec_t tbl [8];

  initial begin
    tbl[0] = '{6'b000100, OP_ADD,    5'd5,  32'h12345678, 1'b1, 32'h12345678, 1'b0};
    tbl[1] = '{6'b000100, OP_ADD,    5'd0,  32'h12345678, 1'b0, 32'h0,        1'b0};
    tbl[2] = '{6'b001000, OP_ADDI,   5'd31, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b0};
    tbl[3] = '{6'b000001, OP_LUI,    5'd1,  32'hABCD0000, 1'b1, 32'hABCD0000, 1'b0};
    tbl[4] = '{6'b010000, OP_SW,     5'd9,  32'h00001000, 1'b0, 32'h0,        1'b0};
    tbl[5] = '{6'b000010, OP_BEQ,    5'd4,  32'h00000040, 1'b0, 32'h0,        1'b0};
    tbl[6] = '{6'b000100, OP_NOTSUP, 5'd6,  32'h55555555, 1'b0, 32'h0,        1'b1};
    tbl[7] = '{6'b000001, OP_JAL,    5'd2,  32'h00000100, 1'b1, 32'h00000100, 1'b0};

    // Reset state
    repeat (2) @(negedge iCLK);
    chk_out("reset", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("reset.rdy", 32'(oEXReady), 32'd1);
    iRST = 1'b0;
    @(negedge iCLK);

    // Back-to-back single-cycle ops from the table
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].ot, tbl[i].op, tbl[i].rd, tbl[i].alu);
      exp_cnt++;
      chk_out($sformatf("tbl%0d", i), tbl[i].we, tbl[i].rd, tbl[i].data, 1'b0, tbl[i].ill);
      chk($sformatf("tbl%0d.rdy", i), 32'(oEXReady), 32'd1);
    end
    @(negedge iCLK);
    chk_out("idle", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // Memory response while idle is ignored
    iDMemValid = 1'b1; iDMemDATA = 32'h11111111;
    @(negedge iCLK);
    iDMemValid = 1'b0;
    chk_out("idle_resp", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);

    // Directed load corner cases
    load_seq("lb3", OP_LB, 5'd8, 32'h00000103, 2, 32'h80FFFFFF, 32'hFFFFFF80);
    load_seq("lhu2", OP_LHU, 5'd9, 32'h00000202, 0, 32'hBEEF1234, 32'h0000BEEF);
    load_seq("lw_rd0", OP_LW, 5'd0, 32'h00000300, 1, 32'hCAFEF00D, 32'hCAFEF00D);
    misal_seq("lw_mis", OP_LW, 5'd3, 32'h00000401);
    misal_seq("lh_mis", OP_LH, 5'd3, 32'h00000403);

    // Execute holds a valid ADD while the stage is stalled on a load
    send(6'b100000, OP_LW, 5'd3, 32'h00000500);
    iEXValid = 1'b1; iOpType = 6'b000100; iDecodedOP = OP_ADD; iDregADDR = 5'd7; iALUDATA = 32'h00C0FFEE;
    @(negedge iCLK);
    chk("hold.rdy", 32'(oEXReady), 32'd0);
    chk("hold.we", 32'(oDregWE), 32'd0);
    iDMemValid = 1'b1; iDMemDATA = 32'h76543210;
    @(negedge iCLK);
    iDMemValid = 1'b0;
    exp_cnt++;
    chk_out("hold.ld", 1'b1, 5'd3, 32'h76543210, 1'b0, 1'b0);
    @(negedge iCLK);
    iEXValid = 1'b0;
    exp_cnt++;
    chk_out("hold.add", 1'b1, 5'd7, 32'h00C0FFEE, 1'b0, 1'b0);

    // Reset mid-load; the response right after reset must be dropped
    send(6'b100000, OP_LB, 5'd4, 32'h00000600);
    iRST = 1'b1;
    @(negedge iCLK);
    iRST = 1'b0;
    iDMemValid = 1'b1; iDMemDATA = 32'h000000AA;
    exp_cnt = 0;
    @(negedge iCLK);
    iDMemValid = 1'b0;
    chk_out("rst_mid", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("rst_mid.rdy", 32'(oEXReady), 32'd1);

`ifdef WB_LOAD_TIMEOUT_EN
    send(6'b100000, OP_LW, 5'd3, 32'h00000700);
    repeat (3) @(negedge iCLK);
    chk("tmo.rdy_wait", 32'(oEXReady), 32'd0);
    chk("tmo.buserr_early", 32'(oBusErr), 32'd0);
    @(negedge iCLK);
    exp_cnt++;
    chk("tmo.buserr", 32'(oBusErr), 32'd1);
    chk_out("tmo", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("tmo.rdy", 32'(oEXReady), 32'd1);
    iDMemValid = 1'b1; iDMemDATA = 32'h12121212;
    @(negedge iCLK);
    iDMemValid = 1'b0;
    chk("tmo.late_buserr", 32'(oBusErr), 32'd0);
    chk_out("tmo.late", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
`endif

    // Randomized mix against the reference model
    for (int n = 0; n < 300; n++) begin
      int          cls;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [9:0]  op;
      logic [31:0] word;
      cls  = $urandom_range(0, 9);
      rd   = 5'($urandom);
      alu  = $urandom;
      word = $urandom;
      if (cls < 4) begin
        case ($urandom_range(0, 2))
          0:       begin op = OP_ADD;  iDMemValid = 1'($urandom); send(6'b000100, op, rd, alu); end
          1:       begin op = OP_ADDI; iDMemValid = 1'($urandom); send(6'b001000, op, rd, alu); end
          default: begin op = OP_LUI;  iDMemValid = 1'($urandom); send(6'b000001, op, rd, alu); end
        endcase
        iDMemValid = 1'b0;
        exp_cnt++;
        chk_out("rnd_alu", rd != 5'd0, rd, alu, 1'b0, 1'b0);
      end else if (cls < 5) begin
        if ($urandom_range(0, 1) == 0) send(6'b010000, OP_SW, rd, alu);
        else                           send(6'b000010, OP_BEQ, rd, alu);
        exp_cnt++;
        chk_out("rnd_nowr", 1'b0, rd, 32'd0, 1'b0, 1'b0);
      end else if (cls < 6) begin
        send(6'b000100, OP_NOTSUP, rd, alu);
        exp_cnt++;
        chk_out("rnd_ill", 1'b0, rd, 32'd0, 1'b0, 1'b1);
      end else begin
        case ($urandom_range(0, 4))
          0:       op = OP_LB;
          1:       op = OP_LBU;
          2:       op = OP_LH;
          3:       op = OP_LHU;
          default: op = OP_LW;
        endcase
        if (misal_ref(op, alu)) misal_seq("rnd_mis", op, rd, alu);
        else load_seq("rnd_ld", op, rd, alu, $urandom_range(0, 3), word, ld_ref(op, alu[1:0], word));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
